// File: rtl/tone_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tone_seq_pkg                                                     |
// | Brief   : Shared types and defaults for the tone sequencer family.         |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package tone_seq_pkg;

    typedef logic [13:0] freq_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        PLAY = 3'd2,
        GAP  = 3'd3,
        END  = 3'd4
    } seq_state_t;

    localparam int c_F_MIN_DEFAULT = 100;
    localparam int c_F_MAX_DEFAULT = 8000;

endpackage
`default_nettype wire

// File: rtl/tone_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tone_sequencer_if                                                |
// | Brief   : Song ROM bus between the sequencer (master) and the ROM (slave). |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface tone_sequencer_if #(
    parameter int ADDR_W = 4
);
    import tone_seq_pkg::*;

    logic [ADDR_W-1:0] note_addr;
    freq_t             note_freq_in;
    logic [3:0]        note_beats_in;

    modport master (
        output note_addr,
        input  note_freq_in,
        input  note_beats_in
    );

    modport slave (
        input  note_addr,
        output note_freq_in,
        output note_beats_in
    );

endinterface
`default_nettype wire

// File: rtl/tone_sequencer_freq_clamp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : freq_clamp                                                       |
// | Brief   : Limits a 14-bit frequency to [F_MIN, F_MAX]; zero (rest) passes. |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module freq_clamp
    import tone_seq_pkg::*;
#(
    parameter int F_MIN = c_F_MIN_DEFAULT,
    parameter int F_MAX = c_F_MAX_DEFAULT
) (
    input  freq_t i_freq,
    output freq_t o_freq
);

    localparam freq_t c_LO = freq_t'(F_MIN);
    localparam freq_t c_HI = freq_t'(F_MAX);

    always_comb begin
        o_freq = i_freq;
        if (i_freq == '0) begin
            o_freq = '0;
        end else if (i_freq < c_LO) begin
            o_freq = c_LO;
        end else if (i_freq > c_HI) begin
            o_freq = c_HI;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tone_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tone_sequencer                                                   |
// | Brief   : Steps through a song ROM and drives the tone generator / gate.   |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tone_sequencer
    import tone_seq_pkg::*;
#(
    parameter int NOTE_COUNT     = 16,
    parameter int ADDR_W         = 4,
    parameter int TICKS_PER_BEAT = 4000,
    parameter int GAP_TICKS      = 320,
    parameter int F_MIN          = c_F_MIN_DEFAULT,
    parameter int F_MAX          = c_F_MAX_DEFAULT
) (
    input  logic             CLK_32KHz,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_en,
    tone_sequencer_if.master rom,
    output freq_t            gen_frequency,
    output logic             gen_phase_rst_n,
    output logic             gate,
    output logic             busy,
    output logic             done
);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(NOTE_COUNT - 1);
    localparam logic [15:0]       c_GAP_LAST  = 16'(GAP_TICKS - 1);

    seq_state_t        r_state, w_nxt_state;
    logic [ADDR_W-1:0] r_addr,  w_nxt_addr;
    freq_t             r_freq,  w_nxt_freq;
    logic [15:0]       r_cnt,   w_nxt_cnt;
    logic              r_gate,  w_nxt_gate;
    logic              r_prst_n, w_nxt_prst_n;
    logic              r_busy;
    logic              r_done,  w_nxt_done;
    freq_t             w_clamped;
    logic [15:0]       w_play_last;

    freq_clamp #(
        .F_MIN (F_MIN),
        .F_MAX (F_MAX)
    ) u_clamp (
        .i_freq (rom.note_freq_in),
        .o_freq (w_clamped)
    );

    // Counter holds remaining PLAY cycles minus one, so PLAY spans beats*T-GAP cycles.
    assign w_play_last = 16'(32'(rom.note_beats_in) * 32'(TICKS_PER_BEAT)
                             - 32'(GAP_TICKS + 1));

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_addr   = r_addr;
        w_nxt_freq   = r_freq;
        w_nxt_cnt    = r_cnt;
        w_nxt_gate   = r_gate;
        w_nxt_prst_n = r_prst_n;
        w_nxt_done   = 1'b0;

        // Abort wins over every other transition, including the END decision.
        if (stop && (r_state != IDLE)) begin
            w_nxt_state  = IDLE;
            w_nxt_addr   = '0;
            w_nxt_freq   = '0;
            w_nxt_cnt    = '0;
            w_nxt_gate   = 1'b0;
            w_nxt_prst_n = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && !stop) begin
                        w_nxt_state  = LOAD;
                        w_nxt_addr   = '0;
                        w_nxt_prst_n = 1'b0;
                    end
                end
                LOAD: begin
                    w_nxt_prst_n = 1'b1;
                    if (rom.note_beats_in == 4'd0) begin
                        w_nxt_state = END;
                        w_nxt_gate  = 1'b0;
                    end else begin
                        w_nxt_state = PLAY;
                        w_nxt_freq  = w_clamped;
                        w_nxt_cnt   = w_play_last;
                        w_nxt_gate  = (w_clamped != '0);
                    end
                end
                PLAY: begin
                    if (r_cnt == 16'd0) begin
                        w_nxt_state = GAP;
                        w_nxt_cnt   = c_GAP_LAST;
                        w_nxt_gate  = 1'b0;
                    end else begin
                        w_nxt_cnt = r_cnt - 16'd1;
                    end
                end
                GAP: begin
                    if (r_cnt != 16'd0) begin
                        w_nxt_cnt = r_cnt - 16'd1;
                    end else if (r_addr == c_LAST_ADDR) begin
                        w_nxt_state = END;
                    end else begin
                        w_nxt_state  = LOAD;
                        w_nxt_addr   = r_addr + 1'b1;
                        w_nxt_prst_n = 1'b0;
                    end
                end
                END: begin
                    w_nxt_addr   = '0;
                    w_nxt_prst_n = 1'b0;
                    w_nxt_gate   = 1'b0;
                    if (loop_en) begin
                        w_nxt_state = LOAD;
                    end else begin
                        w_nxt_state = IDLE;
                        w_nxt_freq  = '0;
                        w_nxt_done  = 1'b1;
                    end
                end
                default: begin
                    w_nxt_state  = IDLE;
                    w_nxt_addr   = '0;
                    w_nxt_freq   = '0;
                    w_nxt_cnt    = '0;
                    w_nxt_gate   = 1'b0;
                    w_nxt_prst_n = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK_32KHz or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_freq   <= '0;
            r_cnt    <= '0;
            r_gate   <= 1'b0;
            r_prst_n <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_nxt_state;
            r_addr   <= w_nxt_addr;
            r_freq   <= w_nxt_freq;
            r_cnt    <= w_nxt_cnt;
            r_gate   <= w_nxt_gate;
            r_prst_n <= w_nxt_prst_n;
            r_busy   <= (w_nxt_state != IDLE);
            r_done   <= w_nxt_done;
        end
    end

    assign rom.note_addr     = r_addr;
    assign gen_frequency     = r_freq;
    assign gen_phase_rst_n   = r_prst_n;
    assign gate              = r_gate;
    assign busy              = r_busy;
    assign done              = r_done;

endmodule
`default_nettype wire

// File: tb/tb_tone_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_tone_sequencer                                                |
// | Brief   : Randomized self-checking bench against a per-cycle song model.   |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_tone_sequencer;

    localparam int c_N   = 4;
    localparam int c_TPB = 10;
    localparam int c_GAP = 2;

    logic clk = 1'b0;
    logic reset_n, start, stop, loop_en;
    logic [13:0] gen_frequency;
    logic gen_phase_rst_n, gate, busy, done;

    logic [13:0] rom_freq  [c_N];
    logic [3:0]  rom_beats [c_N];

    tone_sequencer_if #(.ADDR_W(2)) rom_if ();

    assign rom_if.note_freq_in  = rom_freq[rom_if.note_addr];
    assign rom_if.note_beats_in = rom_beats[rom_if.note_addr];

    tone_sequencer #(
        .NOTE_COUNT     (c_N),
        .ADDR_W         (2),
        .TICKS_PER_BEAT (c_TPB),
        .GAP_TICKS      (c_GAP),
        .F_MIN          (100),
        .F_MAX          (8000)
    ) dut (
        .CLK_32KHz       (clk),
        .reset_n         (reset_n),
        .start           (start),
        .stop            (stop),
        .loop_en         (loop_en),
        .rom             (rom_if),
        .gen_frequency   (gen_frequency),
        .gen_phase_rst_n (gen_phase_rst_n),
        .gate            (gate),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int freq;
        bit gate;
        bit prst;
        bit busy;
        bit done;
    } ev_t;

    ev_t q[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  gate_cnt, done_cnt;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed === expected) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, observed, expected, $time);
    endtask

    function automatic logic [31:0] obs();
        return {12'd0, rom_if.note_addr, done, busy, gen_phase_rst_n, gate, gen_frequency};
    endfunction

    function automatic logic [31:0] pack(input ev_t e);
        return {12'd0, 2'(e.addr), e.done, e.busy, e.prst, e.gate, 14'(e.freq)};
    endfunction

    function automatic int clampf(input int f);
        if (f == 0)    return 0;
        if (f < 100)   return 100;
        if (f > 8000)  return 8000;
        return f;
    endfunction

    function automatic void push(input int a, input int f, input bit g, input bit p,
                                 input bit b, input bit d);
        ev_t e;
        e.addr = a; e.freq = f; e.gate = g; e.prst = p; e.busy = b; e.done = d;
        q.push_back(e);
    endfunction

    // Expected outputs, one entry per cycle, starting with the LOAD cycle after start.
    function automatic void build(input bit lp, input int max_len);
        int addr = 0;
        int cur  = 0;
        q.delete();
        forever begin
            if (q.size() >= max_len) return;
            push(addr, cur, 0, 0, 1, 0);
            if (rom_beats[addr] != 0) begin
                int f = clampf(int'(rom_freq[addr]));
                int n_play = int'(rom_beats[addr]) * c_TPB - c_GAP;
                cur = f;
                for (int i = 0; i < n_play; i++) push(addr, f, f != 0, 1, 1, 0);
                for (int i = 0; i < c_GAP; i++)  push(addr, f, 0, 1, 1, 0);
                if (addr != c_N - 1) begin
                    addr++;
                    continue;
                end
            end
            push(addr, cur, 0, 1, 1, 0);
            if (lp) begin
                addr = 0;
                continue;
            end
            push(0, 0, 0, 0, 0, 1);
            push(0, 0, 0, 0, 0, 0);
            return;
        end
    endfunction

    // stop_at < 0 with lp=1 means abort on the last modelled cycle.
    task automatic run_song(input string tag, input bit lp, input int max_len,
                            input int stop_at, input int start_at);
        int s_at;
        build(lp, max_len);
        s_at = (stop_at < 0 && lp) ? q.size() - 1 : stop_at;
        gate_cnt = 0;
        done_cnt = 0;
        loop_en  = lp;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < q.size(); k++) begin
            chk(tag, obs(), pack(q[k]));
            gate_cnt += int'(gate);
            done_cnt += int'(done);
            start = (k == start_at) && q[k].busy;
            if (k == s_at && q[k].busy) begin
                stop = 1'b1;
                @(negedge clk);
                stop  = 1'b0;
                start = 1'b0;
                chk({tag, "/stop"}, obs(), 32'd0);
                @(negedge clk);
                chk({tag, "/stop_idle"}, obs(), 32'd0);
                return;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic load_rom(input int f0, input int b0, input int f1, input int b1,
                            input int f2, input int b2, input int f3, input int b3);
        rom_freq[0] = 14'(f0); rom_beats[0] = 4'(b0);
        rom_freq[1] = 14'(f1); rom_beats[1] = 4'(b1);
        rom_freq[2] = 14'(f2); rom_beats[2] = 4'(b2);
        rom_freq[3] = 14'(f3); rom_beats[3] = 4'(b3);
    endtask

    function automatic int rand_freq();
        case ($urandom_range(0, 3))
            0:       return 0;
            1:       return int'($urandom_range(1, 99));
            2:       return int'($urandom_range(8001, 16383));
            default: return int'($urandom_range(100, 8000));
        endcase
    endfunction

    function automatic int rand_beats();
        return ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 3));
    endfunction

    initial begin
        reset_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        load_rom(440, 2, 0, 1, 660, 1, 0, 0);
        repeat (2) @(negedge clk);
        chk("reset_state", obs(), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", obs(), 32'd0);

        // Asynchronous reset in the middle of a note.
        loop_en = 1'b0;
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_play_gate", {31'd0, gate}, 32'd1);
        #2 reset_n = 1'b0;
        #1 chk("async_reset", obs(), 32'd0);
        @(negedge clk); reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_idle", obs(), 32'd0);

        run_song("song_basic", 1'b0, 1000, -1, -1);
        chk("gate_cycles", gate_cnt, 32'd26);
        chk("done_pulses", done_cnt, 32'd1);

        run_song("song_loop", 1'b1, 100, -1, -1);
        chk("loop_no_done", done_cnt, 32'd0);

        run_song("stop_play5", 1'b0, 1000, 5, -1);
        chk("stop_no_done", done_cnt, 32'd0);

        run_song("start_in_play", 1'b0, 1000, -1, 3);

        load_rom(50, 1, 9000, 1, 0, 0, 440, 1);
        run_song("clamp", 1'b0, 1000, -1, -1);
        load_rom(30, 1, 9999, 1, 7000, 1, 120, 1);
        run_song("no_marker", 1'b0, 1000, -1, -1);
        chk("no_marker_done", done_cnt, 32'd1);

        @(negedge clk);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("start_stop_idle", obs(), 32'd0);

        for (int s = 0; s < 10; s++) begin
            bit lp;
            int st;
            load_rom(rand_freq(), rand_beats(), rand_freq(), rand_beats(),
                     rand_freq(), rand_beats(), rand_freq(), rand_beats());
            lp = ($urandom_range(0, 2) == 0);
            st = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 60)) : -1;
            run_song("random", lp, 150, st, int'($urandom_range(1, 40)));
            @(negedge clk);
            chk("random_idle", obs(), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
